// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared control-bit positions and named Hack ALU codes
package alu_pkg;

  localparam int OP_ZX = 5;
  localparam int OP_NX = 4;
  localparam int OP_ZY = 3;
  localparam int OP_NY = 2;
  localparam int OP_F  = 1;
  localparam int OP_NO = 0;

  localparam logic [5:0] OP_ZERO = 6'b101010;
  localparam logic [5:0] OP_ONE  = 6'b111111;
  localparam logic [5:0] OP_NEG1 = 6'b111010;
  localparam logic [5:0] OP_X    = 6'b001100;
  localparam logic [5:0] OP_Y    = 6'b110000;
  localparam logic [5:0] OP_NOTX = 6'b001101;
  localparam logic [5:0] OP_NOTY = 6'b110001;
  localparam logic [5:0] OP_NEGX = 6'b001111;
  localparam logic [5:0] OP_NEGY = 6'b110011;
  localparam logic [5:0] OP_XP1  = 6'b011111;
  localparam logic [5:0] OP_YP1  = 6'b110111;
  localparam logic [5:0] OP_XM1  = 6'b001110;
  localparam logic [5:0] OP_YM1  = 6'b110010;
  localparam logic [5:0] OP_ADD  = 6'b000010;
  localparam logic [5:0] OP_XMY  = 6'b010011;
  localparam logic [5:0] OP_YMX  = 6'b000111;
  localparam logic [5:0] OP_AND  = 6'b000000;
  localparam logic [5:0] OP_OR   = 6'b010101;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational Hack ALU back half: preset operands to result and flags
module alu_core #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] xp,
  input  logic [WIDTH-1:0] yp,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cy,
  output logic             ov
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r;

  // Carry and overflow describe the raw add, so they are taken before the 'no' inversion.
  always_comb begin
    sum = {1'b0, xp} + {1'b0, yp};
    r   = f ? sum[WIDTH-1:0] : (xp & yp);
    out = no ? ~r : r;
    zr  = (out == '0);
    ng  = out[WIDTH-1];
    cy  = f & sum[WIDTH];
    ov  = f & (xp[WIDTH-1] == yp[WIDTH-1]) & (sum[WIDTH-1] != xp[WIDTH-1]);
  end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage Hack ALU with valid/ready on both sides and a travelling tag
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       operation,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cy,
  output logic             ov,
  output logic [TAG_W-1:0] out_tag
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_x;
  logic [WIDTH-1:0] s1_y;
  logic             s1_f;
  logic             s1_no;
  logic [TAG_W-1:0] s1_tag;

  logic             s1_advance;
  logic             in_fire;
  logic [WIDTH-1:0] x_pre;
  logic [WIDTH-1:0] y_pre;
  logic [WIDTH-1:0] core_out;
  logic             core_zr;
  logic             core_ng;
  logic             core_cy;
  logic             core_ov;

  always_comb begin
    x_pre = operation[OP_ZX] ? '0 : x;
    if (operation[OP_NX]) x_pre = ~x_pre;
    y_pre = operation[OP_ZY] ? '0 : y;
    if (operation[OP_NY]) y_pre = ~y_pre;
  end

  // S1 moves on whenever S2 is empty or emptying this cycle.
  assign s1_advance = s1_valid & (~out_valid | out_ready);
  assign in_ready   = ~s1_valid | s1_advance;
  assign in_fire    = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_f     <= 1'b0;
      s1_no    <= 1'b0;
      s1_tag   <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_x     <= x_pre;
      s1_y     <= y_pre;
      s1_f     <= operation[OP_F];
      s1_no    <= operation[OP_NO];
      s1_tag   <= in_tag;
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .xp  (s1_x),
    .yp  (s1_y),
    .f   (s1_f),
    .no  (s1_no),
    .out (core_out),
    .zr  (core_zr),
    .ng  (core_ng),
    .cy  (core_cy),
    .ov  (core_ov)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      zr        <= 1'b0;
      ng        <= 1'b0;
      cy        <= 1'b0;
      ov        <= 1'b0;
      out_tag   <= '0;
    end else if (s1_advance) begin
      out_valid <= 1'b1;
      out       <= core_out;
      zr        <= core_zr;
      ng        <= core_ng;
      cy        <= core_cy;
      ov        <= core_ov;
      out_tag   <= s1_tag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
